// File: rtl/step_pulse_gen.sv
// Step-pulse generator: programmable period/high time, counted or continuous moves,
// speed changes applied only at step boundaries, graceful stop at the next boundary.
module step_pulse_gen #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  pulse_len,
  input  logic [STEP_W-1:0] steps,
  output logic              step_out,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   ph, ph_nx, per_r, per_nx, hi_r, hi_nx;
  logic [CNT_W-1:0]   p_eff, h_eff;
  logic               mode_r, mode_nx;
  logic [STEP_W-1:0]  steps_r, steps_nx, cnt_nx, cnt_inc;
  logic               stop_pend, stop_nx;
  logic               step_nx, done_nx;
  logic               at_bnd, last_step;

  // Effective P/H from the live inputs; only consumed on start or at a boundary.
  always_comb begin
    p_eff = (period < CNT_W'(2)) ? CNT_W'(2) : period;
    if (pulse_len == '0)
      h_eff = CNT_W'(1);
    else if (pulse_len >= p_eff)
      h_eff = p_eff - CNT_W'(1);
    else
      h_eff = pulse_len;
  end

  assign at_bnd    = (ph == per_r - CNT_W'(1));
  assign last_step = !mode_r && (step_cnt == steps_r - STEP_W'(1));
  assign cnt_inc   = (&step_cnt) ? step_cnt : step_cnt + STEP_W'(1);
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    per_nx   = per_r;
    hi_nx    = hi_r;
    mode_nx  = mode_r;
    steps_nx = steps_r;
    cnt_nx   = step_cnt;
    stop_nx  = stop_pend;
    step_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_nx  = mode;
          steps_nx = steps;
          cnt_nx   = '0;
          stop_nx  = 1'b0;
          ph_nx    = '0;
          per_nx   = p_eff;
          hi_nx    = h_eff;
          if (!mode && steps == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx = RUN;
            step_nx  = 1'b1;
          end
        end
      end
      RUN: begin
        stop_nx = stop_pend | stop;
        if (at_bnd) begin
          cnt_nx = cnt_inc;
          ph_nx  = '0;
          if (last_step || stop_pend || stop) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            stop_nx  = 1'b0;
          end else begin
            per_nx  = p_eff;
            hi_nx   = h_eff;
            step_nx = 1'b1;
          end
        end else begin
          ph_nx   = ph + CNT_W'(1);
          step_nx = (ph + CNT_W'(1)) < hi_r;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // step_out is registered from the next phase so it lines up with ph in each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= '0;
      per_r     <= CNT_W'(2);
      hi_r      <= CNT_W'(1);
      mode_r    <= 1'b0;
      steps_r   <= '0;
      step_cnt  <= '0;
      stop_pend <= 1'b0;
      step_out  <= 1'b0;
      done      <= 1'b0;
    end else begin
      ph        <= ph_nx;
      per_r     <= per_nx;
      hi_r      <= hi_nx;
      mode_r    <= mode_nx;
      steps_r   <= steps_nx;
      step_cnt  <= cnt_nx;
      stop_pend <= stop_nx;
      step_out  <= step_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Parametrised step-pulse generator for the step-motor datapath, successor to the fixed free-running cycle counter. It produces a train of step pulses with programmable period and high time, either continuously or for a programmed number of steps. It supports glitch-free speed changes at step boundaries and a graceful stop, and reports busy, done and the completed-step count. It sits between the motion controller (period and step commands) and the motor driver STEP pin.

## Interface
- `CNT_W`, default 32: width of the period and pulse-length counters.
- `STEP_W`, default 16: width of the step target and step counter.
- `clk`  in  1  system clock (50 MHz); all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a move; sampled only in IDLE.
- `stop`  in  1  graceful stop request; sampled only in RUN.
- `mode`  in  1  0 = counted (run `steps` steps), 1 = continuous.
- `period`  in  CNT_W  step period in clk cycles.
- `pulse_len`  in  CNT_W  step high time in clk cycles.
- `steps`  in  STEP_W  step target for counted mode.
- `step_out`  out  1  registered step pulse to the driver.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a move ends.
- `step_cnt`  out  STEP_W  completed steps of the current or last move.

## Operation
- The block has two states, IDLE and RUN.
- **Effective values**
  - Effective period: P = max(`period`, 2).
  - Effective high time: H = `pulse_len` clamped to [1, P-1].
  - All comparisons are unsigned.
- **IDLE**
  - `start`=1 latches `mode` and `steps`, computes P and H from the current inputs, clears `step_cnt`, sets phase counter ph=0 and enters RUN.
  - `stop` is ignored in IDLE.
- **Zero-step case:** counted mode with `steps`=0 on `start` does not enter RUN. `done` pulses the next cycle, `step_out` stays 0 and `step_cnt`=0.
- **RUN**
  - ph counts 0..P-1.
  - `step_out` = (ph < H), registered.
  - At ph = P-1, a step completes: `step_cnt` increments and saturates at 2^STEP_W-1.
- **Step boundary (ph = P-1)**
  - Counted mode, and this is step number `steps`: go to IDLE and pulse `done`.
  - A stop is pending: go to IDLE and pulse `done`.
  - Otherwise, set ph=0 and re-sample `period`/`pulse_len` into new P/H. Speed changes therefore take effect only at step boundaries, and pulses are never truncated or stretched.
- **Stop**
  - `stop` in RUN sets a sticky stop-pending flag. The current step finishes fully, then the move ends at that boundary.
  - `stop` on the exact boundary cycle ends the move at that same boundary.
- `start` during RUN is ignored; `mode` and `steps` are frozen for the whole move.
- `step_cnt` holds its value in IDLE until the next accepted `start`.

## Timing
- **Reset:** while `rst_n`=0, every output is 0 (`step_out`, `busy`, `done`, `step_cnt`), state is IDLE, ph=0 and stop-pending=0. Reset mid-move aborts immediately with no `done`.
- **Cycle numbering:** `start` is sampled in cycle 0.
  - Step k (k from 0) occupies cycles kP+1 .. (k+1)P.
  - `step_out` is high in cycles kP+1 .. kP+H.
- **Busy:** `busy`=1 in cycles 1..NP for an N-step counted move.
- **End of a counted move:** `done`=1 for exactly cycle NP+1, with `busy`=0 and `step_cnt`=N in that cycle.
- **Back-to-back moves:** the IDLE cycle NP+1 may sample a new `start`. Its first pulse then begins in cycle NP+2.
- **Zero-step case:** `done` is high in cycle 1 and `busy` never rises.
- **Counter count-up:** `step_cnt` updates in the cycle after the last phase of each step.
- **Stop latency:** at most P cycles from the `stop` sample to `done`.
- **Pulse guarantees:** minimum high time is 1 cycle and minimum low time is 1 cycle.

## Test plan
- **Basic counted move:** reset, then `mode`=0, `period`=4, `pulse_len`=2, `steps`=3, `start` in cycle 0.
  - `step_out` high in cycles 1-2, 5-6 and 9-10.
  - `busy` high in cycles 1-12.
  - `done` in cycle 13 with `step_cnt`=3.
- **Clamping:** `period`=0, `pulse_len`=0, `steps`=2 gives P=2, H=1, so `step_out` is high in cycles 1 and 3 and `done` is in cycle 5. Separately, `period`=5 with `pulse_len`=9 gives H=4.
- **Continuous mode, speed change and stop:** `mode`=1, `period`=10, `pulse_len`=5.
  - Change `period` to 6 in cycle 13: step 1 still spans cycles 11-20, and step 2 spans cycles 21-26 with high in cycles 21-25.
  - `stop` in cycle 23: `done` in cycle 27 with `step_cnt`=3.
- **Edge cases:**
  - `steps`=0 `start`: `done` in cycle 1 with no pulses.
  - `start` during RUN is ignored.
  - A new `start` in the `done` cycle is accepted back-to-back.
- **Reset mid-move:** assert `rst_n`=0 during a high phase of step 1. All outputs drop to 0 asynchronously and no `done` is generated. After release, a new move runs from `step_cnt`=0.
- **Saturation:** with STEP_W=4, continuous mode, `period`=2, run 20 steps. `step_cnt` sticks at 15 while pulses continue.
